// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one slow_memory port between the I-cache and
// D-cache, with one transaction in flight and a registered grant decision.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  // State encodings double as the grant output value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;
  logic   i_pend, d_pend;

  assign i_pend = I_read | I_write;
  assign d_pend = D_read | D_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    I_rdata    = '0;
    I_ready    = 1'b0;
    D_rdata    = '0;
    D_ready    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    grant      = state;
    case (state)
      IDLE: begin
        // On a tie, the requester that did not own memory last time wins.
        if (i_pend && d_pend)
          state_nxt = last_d ? GNT_I : GNT_D;
        else if (i_pend)
          state_nxt = GNT_I;
        else if (d_pend)
          state_nxt = GNT_D;
      end
      GNT_I: begin
        mem_read  = I_read;
        mem_write = I_write;
        mem_addr  = I_addr;
        mem_wdata = I_wdata;
        I_ready   = mem_ready;
        I_rdata   = mem_rdata;
        if (mem_ready) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b0;
        end
      end
      GNT_D: begin
        mem_read  = D_read;
        mem_write = D_write;
        mem_addr  = D_addr;
        mem_wdata = D_wdata;
        D_ready   = mem_ready;
        D_rdata   = mem_rdata;
        if (mem_ready) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
